// File: rtl/k12_job_if.sv
// Port bundle for k12_job_ctrl: host job/result handshakes plus the shared PoW core bus.
// slave = controller side, master = host/core-array side.
interface k12_job_if #(
  parameter int NCORE  = 4,
  parameter int ITER_W = 32
);
  logic                  job_valid;
  logic                  job_ready;
  logic [575:0]          job_blob;
  logic [63:0]           job_target;
  logic [ITER_W-1:0]     job_iters;
  logic                  stop;
  logic                  core_load;
  logic                  core_start;
  logic [575:0]          core_blob;
  logic [63:0]           core_target;
  logic [NCORE-1:0]      core_store;
  logic [64*NCORE-1:0]   core_nonce;
  logic                  res_valid;
  logic                  res_ready;
  logic [63:0]           res_nonce;
  logic                  busy;
  logic                  overflow;
  logic [ITER_W-1:0]     rounds;

  modport slave (
    input  job_valid, job_blob, job_target, job_iters, stop, core_store, core_nonce, res_ready,
    output job_ready, core_load, core_start, core_blob, core_target, res_valid, res_nonce,
           busy, overflow, rounds
  );

  modport master (
    output job_valid, job_blob, job_target, job_iters, stop, core_store, core_nonce, res_ready,
    input  job_ready, core_load, core_start, core_blob, core_target, res_valid, res_nonce,
           busy, overflow, rounds
  );
endinterface

// File: rtl/k12_job_ctrl.sv
// K12 PoW job dispatcher: issues load/start strobes to the core array at the hash cadence
// and funnels per-core nonce hits through a round-robin arbiter into a show-ahead FIFO.
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_IDLE  | waiting for a job, job_ready high
// S_LOAD  | one-cycle core_load strobe with the latched blob/target
// S_RUN   | core_start every HASH_CYCLES cycles until budget spent or stop
// S_DRAIN | HASH_CYCLES+2 cycles so in-flight hits can land, then idle
module k12_job_ctrl #(
  parameter int NCORE       = 4,
  parameter int HASH_CYCLES = 13,
  parameter int FIFO_DEPTH  = 8,
  parameter int ITER_W      = 32
) (
  input logic      clk,
  input logic      rst,
  k12_job_if.slave bus
);

  localparam int CW = $clog2(HASH_CYCLES + 2);
  localparam int PW = (NCORE > 1) ? $clog2(NCORE) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_PERIOD = CW'(HASH_CYCLES - 1);
  localparam logic [CW-1:0] CNT_DRAIN  = CW'(HASH_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              accept, load, start;
  logic [575:0]      blob_q;
  logic [63:0]       target_q;
  logic [ITER_W-1:0] iters_q, rounds_q;
  logic              overflow_q;

  logic [NCORE-1:0]  hold_full;
  logic [63:0]       hold_nonce [NCORE];
  logic [NCORE-1:0]  drop;
  logic [PW-1:0]     rr_ptr, gnt_idx;
  logic              gnt_found, push, pop;

  logic [63:0]       fifo_mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              fifo_full, fifo_empty;

  // One counter serves as the cadence timer in RUN and the drain timer in DRAIN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    load    = 1'b0;
    start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.job_valid) begin
          accept  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        load  = 1'b1;
        cnt_d = '0;
        if (bus.stop) begin
          state_d = S_DRAIN;
          cnt_d   = CNT_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        start = (cnt_q == '0);
        cnt_d = start ? CNT_PERIOD : cnt_q - CW'(1);
        if (bus.stop || (start && iters_q != '0 && (rounds_q + ITER_W'(1)) == iters_q)) begin
          state_d = S_DRAIN;
          cnt_d   = CNT_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      blob_q   <= '0;
      target_q <= '0;
      iters_q  <= '0;
      rounds_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        blob_q   <= bus.job_blob;
        target_q <= bus.job_target;
        iters_q  <= bus.job_iters;
        rounds_q <= '0;
      end else if (start) begin
        rounds_q <= rounds_q + ITER_W'(1);
      end
    end
  end

  // Round-robin: first full register at or above the pointer, else first full below it.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NCORE; i++) begin
      if (!gnt_found && hold_full[i] && PW'(i) >= rr_ptr) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(i);
      end
    end
    for (int i = 0; i < NCORE; i++) begin
      if (!gnt_found && hold_full[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(i);
      end
    end
  end

  assign push = gnt_found && !fifo_full;
  assign pop  = !fifo_empty && bus.res_ready;

  // A register being emptied into the FIFO this cycle may accept a new hit.
  always_comb begin
    drop = '0;
    for (int i = 0; i < NCORE; i++) begin
      drop[i] = bus.core_store[i] && hold_full[i] && !(push && gnt_idx == PW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_full  <= '0;
      rr_ptr     <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < NCORE; i++) hold_nonce[i] <= '0;
    end else begin
      for (int i = 0; i < NCORE; i++) begin
        if (bus.core_store[i] && !drop[i]) begin
          hold_full[i]  <= 1'b1;
          hold_nonce[i] <= bus.core_nonce[64*i +: 64];
        end else if (push && gnt_idx == PW'(i)) begin
          hold_full[i] <= 1'b0;
        end
      end
      if (push) rr_ptr <= (gnt_idx == PW'(NCORE - 1)) ? '0 : gnt_idx + PW'(1);
      if (|drop)       overflow_q <= 1'b1;
      else if (accept) overflow_q <= 1'b0;
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= hold_nonce[gnt_idx];
  end

  assign bus.job_ready   = rst && (state_q == S_IDLE);
  assign bus.core_load   = rst && load;
  assign bus.core_start  = rst && start;
  assign bus.core_blob   = blob_q;
  assign bus.core_target = target_q;
  assign bus.res_valid   = !fifo_empty;
  assign bus.res_nonce   = fifo_empty ? '0 : fifo_mem[rd_ptr[AW-1:0]];
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.overflow    = overflow_q;
  assign bus.rounds      = rounds_q;

endmodule

// File: tb/tb_k12_job_ctrl.sv
// Directed bench for k12_job_ctrl: strobe cadence, stop/drain, arbitration order,
// overflow and reset, with a nonce scoreboard checked at every result handshake.
module tb_k12_job_ctrl;

  localparam int NCORE  = 4;
  localparam int HC     = 13;
  localparam int ITER_W = 32;

  logic clk;
  logic rst;

  k12_job_if #(.NCORE(NCORE), .ITER_W(ITER_W)) bus ();

  k12_job_ctrl #(
    .NCORE(NCORE), .HASH_CYCLES(HC), .FIFO_DEPTH(8), .ITER_W(ITER_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [63:0] sb [$];
  logic [63:0] sb_exp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_sb(input string tag, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  // Result consumer side: every handshake must deliver the oldest expected nonce.
  always @(negedge clk) begin
    if (rst && bus.res_valid && bus.res_ready) begin
      if (sb.size() != 0) sb_exp = sb.pop_front();
      else                sb_exp = '1;
      check("sb_nonce", bus.res_nonce, sb_exp);
    end
  end

  int nstart;
  int st [4];
  int low_k;

  initial begin
    rst            = 1'b0;
    bus.job_valid  = 1'b0;
    bus.job_blob   = '0;
    bus.job_target = '0;
    bus.job_iters  = '0;
    bus.stop       = 1'b0;
    bus.core_store = '0;
    bus.core_nonce = '0;
    bus.res_ready  = 1'b1;
    tick();
    tick();
    check("rst_job_ready", bus.job_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_rounds", bus.rounds, 0);
    check("rst_core_start", bus.core_start, 0);
    check("rst_blob_zero", bus.core_blob == '0, 1);
    rst = 1'b1;
    tick();
    check("idle_job_ready", bus.job_ready, 1);

    // Job with a 3-start budget: load at T+1, starts at T+2/15/28, idle 15 cycles after DRAIN.
    bus.job_valid  = 1'b1;
    bus.job_blob   = 576'h1;
    bus.job_target = 64'h10;
    bus.job_iters  = 3;
    tick();
    bus.job_valid = 1'b0;
    check("j1_load", bus.core_load, 1);
    check("j1_start_k1", bus.core_start, 0);
    check("j1_job_ready", bus.job_ready, 0);
    check("j1_blob", bus.core_blob == 576'h1, 1);
    check("j1_target", bus.core_target, 64'h10);
    nstart = 0; low_k = 0;
    for (int i = 0; i < 4; i++) st[i] = -1;
    for (int k = 2; k <= 50; k++) begin
      tick();
      if (k == 2) check("j1_load_once", bus.core_load, 0);
      if (bus.core_start) begin
        if (nstart < 4) st[nstart] = k;
        nstart++;
      end
      if (!bus.busy && low_k == 0) low_k = k;
    end
    check("j1_nstart", 64'(nstart), 3);
    check("j1_start0", 64'(st[0]), 2);
    check("j1_start1", 64'(st[1]), 15);
    check("j1_start2", 64'(st[2]), 28);
    check("j1_busy_low", 64'(low_k), 44);
    check("j1_rounds", bus.rounds, 3);

    // Simultaneous hits on cores 0 and 2 with the pointer at 0.
    bus.core_store = 4'b0101;
    bus.core_nonce[63:0]    = 64'h100;
    bus.core_nonce[191:128] = 64'h102;
    sb.push_back(64'h100);
    sb.push_back(64'h102);
    tick();
    bus.core_store = '0;
    check("hit_lat_e", bus.res_valid, 0);
    tick();
    check("hit_lat_e1", bus.res_valid, 1);
    check("hit_head0", bus.res_nonce, 64'h100);
    tick();
    check("hit_head1", bus.res_nonce, 64'h102);
    tick();
    tick();

    // Core 0 alone, then pair 1/2 (core 1 first), then pair 0/3 (core 3 first).
    bus.core_store = 4'b0001; bus.core_nonce[63:0] = 64'h200;
    sb.push_back(64'h200);
    tick(); bus.core_store = '0; tick(); tick(); tick();
    bus.core_store = 4'b0110;
    bus.core_nonce[127:64]  = 64'h301;
    bus.core_nonce[191:128] = 64'h302;
    sb.push_back(64'h301); sb.push_back(64'h302);
    tick(); bus.core_store = '0; tick(); tick(); tick();
    bus.core_store = 4'b1001;
    bus.core_nonce[63:0]    = 64'h300;
    bus.core_nonce[255:192] = 64'h303;
    sb.push_back(64'h303); sb.push_back(64'h300);
    tick(); bus.core_store = '0;
    drain_sb("rr_drained", 20);

    // Overflow: 10 hits from core 0 with no consumer; 8 in FIFO, 1 held, 1 dropped.
    bus.res_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) check("ovf_before", bus.overflow, 0);
      bus.core_store = 4'b0001;
      bus.core_nonce[63:0] = 64'h400 + 64'(i);
      if (i < 9) sb.push_back(64'h400 + 64'(i));
      tick();
      bus.core_store = '0;
      if (i < 9) for (int j = 0; j < 12; j++) tick();
    end
    check("ovf_set", bus.overflow, 1);
    check("ovf_head", bus.res_nonce, 64'h400);
    bus.res_ready = 1'b1;
    drain_sb("ovf_drained", 40);
    tick();
    check("ovf_empty", bus.res_valid, 0);
    check("ovf_sticky", bus.overflow, 1);

    // Unbounded job, stop in the cycle after the second start; hit lands during DRAIN.
    bus.job_valid = 1'b1;
    bus.job_iters = 0;
    tick();
    bus.job_valid = 1'b0;
    check("j4_ovf_clear", bus.overflow, 0);
    nstart = 0; low_k = 0;
    for (int k = 2; k <= 60; k++) begin
      tick();
      if (bus.core_start) nstart++;
      if (!bus.busy && low_k == 0) low_k = k;
      if (k == 16) bus.stop = 1'b1;
      if (k == 20) begin
        bus.core_store = 4'b0010;
        bus.core_nonce[127:64] = 64'h501;
        sb.push_back(64'h501);
      end
      if (k == 21) begin
        bus.core_store = '0;
        bus.stop = 1'b0;
      end
    end
    check("j4_nstart", 64'(nstart), 2);
    check("j4_rounds", bus.rounds, 2);
    check("j4_busy_low", 64'(low_k), 32);
    drain_sb("j4_hit_drained", 10);

    // Stop during LOAD: no starts at all.
    bus.job_valid = 1'b1;
    tick();
    bus.job_valid = 1'b0;
    bus.stop = 1'b1;
    check("j5_load", bus.core_load, 1);
    nstart = 0; low_k = 0;
    for (int k = 2; k <= 30; k++) begin
      tick();
      if (k == 2) bus.stop = 1'b0;
      if (bus.core_start) nstart++;
      if (!bus.busy && low_k == 0) low_k = k;
    end
    check("j5_nstart", 64'(nstart), 0);
    check("j5_rounds", bus.rounds, 0);
    check("j5_busy_low", 64'(low_k), 17);

    // Reset mid-RUN with three queued results, on the edge that would start round 2.
    bus.res_ready = 1'b0;
    bus.job_valid = 1'b1;
    tick();
    bus.job_valid = 1'b0;
    for (int k = 2; k <= 14; k++) begin
      tick();
      if (k == 3) begin
        bus.core_store = 4'b0111;
        bus.core_nonce[63:0]    = 64'h600;
        bus.core_nonce[127:64]  = 64'h601;
        bus.core_nonce[191:128] = 64'h602;
      end
      if (k == 4) bus.core_store = '0;
      if (k == 10) begin
        check("j6_res_valid", bus.res_valid, 1);
        check("j6_rr_head", bus.res_nonce, 64'h602);
      end
    end
    rst = 1'b0;
    tick();
    check("j6_rst_start", bus.core_start, 0);
    check("j6_rst_res_valid", bus.res_valid, 0);
    check("j6_rst_busy", bus.busy, 0);
    check("j6_rst_rounds", bus.rounds, 0);
    check("j6_rst_job_ready", bus.job_ready, 0);
    rst = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    check("j6_job_ready", bus.job_ready, 1);
    tick();
    tick();
    check("j6_fifo_lost", bus.res_valid, 0);
    check("sb_final", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
